// File: rtl/mem_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: FSM states and job modes.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, NEXT, FIN, ERR
  } state_e;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RD    = 2'd0;
  localparam mode_t MODE_WR    = 2'd1;
  localparam mode_t MODE_WR_RD = 2'd2;
  localparam mode_t MODE_RSVD  = 2'd3;

  // Modes whose iteration begins with a write access.
  function automatic logic mode_starts_wr(mode_t m);
    return (m == MODE_WR) || (m == MODE_WR_RD);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Issue/completion link between the sequencer (master) and the access engine (slave).
interface mem_access_sequencer_if #(parameter int ADDR_W = 30);
  logic              GoRead;
  logic              GoWrite;
  logic [ADDR_W-1:0] source_address;
  logic [ADDR_W-1:0] destination_address;
  logic              rd_done;
  logic              wr_done;

  modport master (output GoRead, GoWrite, source_address, destination_address,
                  input  rd_done, wr_done);
  modport slave  (input  GoRead, GoWrite, source_address, destination_address,
                  output rd_done, wr_done);
endinterface

// File: rtl/mem_access_sequencer_lat_stats.sv
// Min/max/saturating-sum of per-access completion latency; built with MEM_SEQ_LAT_STATS_EN.
module mem_seq_lat_stats #(
  parameter int TMO_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [TMO_W-1:0] lat_i,
  output logic [TMO_W-1:0] lat_min_o,
  output logic [TMO_W-1:0] lat_max_o,
  output logic [31:0]      lat_sum_o
);
  logic [TMO_W-1:0] min_q, max_q;
  logic [31:0]      sum_q;
  logic [32:0]      sum_ext;

  assign sum_ext = {1'b0, sum_q} + 33'(lat_i);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else if (clr_i) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else if (vld_i) begin
      if (lat_i < min_q) min_q <= lat_i;
      if (lat_i > max_q) max_q <= lat_i;
      sum_q <= sum_ext[32] ? '1 : sum_ext[31:0];
    end
  end

  assign lat_min_o = min_q;
  assign lat_max_o = max_q;
  assign lat_sum_o = sum_q;
endmodule

// File: rtl/mem_access_sequencer.sv
// Base/stride/count job sequencer driving a single-beat access engine, one access at a time.
// Optional latency statistics ports when MEM_SEQ_LAT_STATS_EN is defined.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int CNT_W  = 16,
  parameter int TMO_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Abort,
  input  mode_t             cfg_mode,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [TMO_W-1:0]  cfg_timeout,
  mem_access_sequencer_if.master eng,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
`ifdef MEM_SEQ_LAT_STATS_EN
  output logic [TMO_W-1:0]  lat_min,
  output logic [TMO_W-1:0]  lat_max,
  output logic [31:0]       lat_sum,
`endif
  output logic [CNT_W-1:0]  iter_cnt
);
  state_e            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] stride_q, stride_d, src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]  count_q, count_d, iter_q, iter_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, timer_q, timer_d;
  logic              err_q, err_d;
  logic              start_acc;

  assign start_acc = Start && !Abort && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    stride_d = stride_q;
    count_d  = count_q;
    tmo_d    = tmo_q;
    src_d    = src_q;
    dst_d    = dst_q;
    iter_d   = iter_q;
    timer_d  = timer_q;
    err_d    = err_q;
    if (Abort) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (Start) begin
          mode_d   = (cfg_mode == MODE_RSVD) ? MODE_RD : cfg_mode;
          stride_d = cfg_stride;
          count_d  = cfg_count;
          tmo_d    = cfg_timeout;
          src_d    = cfg_src_base;
          dst_d    = cfg_dst_base;
          iter_d   = '0;
          timer_d  = '0;
          err_d    = 1'b0;
          if (cfg_count == '0)            state_d = FIN;
          else if (mode_starts_wr(cfg_mode)) state_d = ISSUE_WR;
          else                            state_d = ISSUE_RD;
        end
        ISSUE_WR: begin
          timer_d = '0;
          state_d = WAIT_WR;
        end
        ISSUE_RD: begin
          timer_d = '0;
          state_d = WAIT_RD;
        end
        // A completion arriving on the timeout cycle still counts as success.
        WAIT_WR: begin
          if (eng.wr_done)             state_d = (mode_q == MODE_WR_RD) ? ISSUE_RD : NEXT;
          else if (timer_q == tmo_q) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else                     timer_d = timer_q + TMO_W'(1);
        end
        WAIT_RD: begin
          if (eng.rd_done)             state_d = NEXT;
          else if (timer_q == tmo_q) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else                     timer_d = timer_q + TMO_W'(1);
        end
        NEXT: begin
          iter_d = iter_q + CNT_W'(1);
          src_d  = src_q + stride_q;
          dst_d  = dst_q + stride_q;
          if (iter_d == count_q)          state_d = FIN;
          else if (mode_starts_wr(mode_q)) state_d = ISSUE_WR;
          else                            state_d = ISSUE_RD;
        end
        FIN:     state_d = IDLE;
        ERR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_RD;
      stride_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      iter_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      stride_q <= stride_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      iter_q   <= iter_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  assign eng.GoWrite             = (state_q == ISSUE_WR);
  assign eng.GoRead              = (state_q == ISSUE_RD);
  assign eng.source_address      = src_q;
  assign eng.destination_address = dst_q;
  assign Busy                    = (state_q != IDLE);
  assign Done                    = (state_q == FIN);
  assign Error                   = err_q;
  assign iter_cnt                = iter_q;

`ifdef MEM_SEQ_LAT_STATS_EN
  // Latency is the number of WAIT cycles spent, completion cycle included.
  logic             lat_vld;
  logic [TMO_W-1:0] lat_val;
  assign lat_vld = !Abort && (((state_q == WAIT_WR) && eng.wr_done) ||
                              ((state_q == WAIT_RD) && eng.rd_done));
  assign lat_val = (&timer_q) ? timer_q : timer_q + TMO_W'(1);

  mem_seq_lat_stats #(.TMO_W(TMO_W)) u_lat_stats (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .clr_i     (start_acc),
    .vld_i     (lat_vld),
    .lat_i     (lat_val),
    .lat_min_o (lat_min),
    .lat_max_o (lat_max),
    .lat_sum_o (lat_sum)
  );
`endif
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized scoreboard bench: a job model predicts Go/Done/Error events, a monitor checks them.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;
  localparam int AW = 30, CW = 16, TW = 16;

  logic Clk = 1'b0, Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic          Start = 1'b0, Abort = 1'b0;
  mode_t         cfg_mode = '0;
  logic [AW-1:0] cfg_src_base = '0, cfg_dst_base = '0, cfg_stride = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [TW-1:0] cfg_timeout = '0;
  logic          Busy, Done, Error;
  logic [CW-1:0] iter_cnt;
`ifdef MEM_SEQ_LAT_STATS_EN
  logic [TW-1:0] lat_min, lat_max;
  logic [31:0]   lat_sum;
`endif

  mem_access_sequencer_if #(.ADDR_W(AW)) eng();

  mem_access_sequencer #(.ADDR_W(AW), .CNT_W(CW), .TMO_W(TW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort), .cfg_mode(cfg_mode),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_stride(cfg_stride),
    .cfg_count(cfg_count), .cfg_timeout(cfg_timeout), .eng(eng.master),
    .Busy(Busy), .Done(Done), .Error(Error),
`ifdef MEM_SEQ_LAT_STATS_EN
    .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
`endif
    .iter_cnt(iter_cnt)
  );

  // kind: 0 read issue, 1 write issue, 2 Done, 3 Error
  typedef struct {int kind; logic [AW-1:0] addr; int iter;} ev_t;
  ev_t exp_q[$];
  int  dly_q[$];
  int  total = 0, bad = 0;
  int  cyc = 0, last_go_cyc = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Monitor: pops one expected event for each Go pulse, Done pulse or Error rise.
  logic err_prev = 1'b0, busy_chk = 1'b0;
  int   mk;
  ev_t  me;
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (busy_chk) begin
        chk("busy_low_after_end", Busy, 0);
        busy_chk = 1'b0;
      end
      if (eng.GoRead || eng.GoWrite || Done || (Error && !err_prev)) begin
        mk = eng.GoRead ? 0 : eng.GoWrite ? 1 : Done ? 2 : 3;
        if (mk < 2) last_go_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: got kind %0d expected none", mk);
        end else begin
          me = exp_q.pop_front();
          chk("event_kind", mk, me.kind);
          if (mk == 0) chk("rd_addr", eng.source_address, me.addr);
          if (mk == 1) chk("wr_addr", eng.destination_address, me.addr);
          if (mk >= 2) begin
            chk("iter_at_end", iter_cnt, me.iter);
            busy_chk = 1'b1;
          end
        end
      end
    end
    err_prev = Error;
  end

  // Engine responder: d>0 completes d cycles after the Go pulse, d==0 never answers.
  int  rd_d;
  logic rsp_rd;
  initial begin
    eng.rd_done = 1'b0;
    eng.wr_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst_n && (eng.GoRead || eng.GoWrite)) begin
        rsp_rd = eng.GoRead;
        rd_d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        if (rd_d > 0) begin
          repeat (rd_d) @(posedge Clk);
          #1;
          if (rsp_rd) eng.rd_done = 1'b1; else eng.wr_done = 1'b1;
          @(posedge Clk);
          #1;
          eng.rd_done = 1'b0;
          eng.wr_done = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  // Reference model: walk iterations, emit accesses; a non-answered or late access ends in Error.
  task automatic run_job(int m, logic [AW-1:0] src, logic [AW-1:0] dst, logic [AW-1:0] stride,
                         int cnt, int tmo, int fixed_d, int fail_at);
    logic [AW-1:0] s, w, a;
    int kinds[$];
    int acc, d, n;
    bit err;
    ev_t e;
    s = src; w = dst; acc = 0; err = 0;
    if (m == 1)      kinds = '{1};
    else if (m == 2) kinds = '{1, 0};
    else             kinds = '{0};
    for (int it = 0; it < cnt && !err; it++) begin
      foreach (kinds[j]) begin
        if (!err) begin
          a = kinds[j] ? w : s;
          e = '{kinds[j], a, 0};
          exp_q.push_back(e);
          d = (acc == fail_at) ? 0 : (fixed_d > 0) ? fixed_d : int'($urandom_range(1, tmo + 1));
          dly_q.push_back(d);
          if (d == 0 || d > tmo + 1) begin
            e = '{3, '0, it};
            exp_q.push_back(e);
            err = 1;
          end
          acc++;
        end
      end
      s = s + stride;
      w = w + stride;
    end
    if (!err) begin
      e = '{2, '0, cnt};
      exp_q.push_back(e);
    end
    cfg_mode = mode_t'(m); cfg_src_base = src; cfg_dst_base = dst; cfg_stride = stride;
    cfg_count = CW'(cnt); cfg_timeout = TW'(tmo);
    pulse_start();
    @(negedge Clk);
    if (cnt > 0) chk("go_latency", (m == 1 || m == 2) ? eng.GoWrite : eng.GoRead, 1);
    else         chk("count0_no_go", eng.GoRead | eng.GoWrite, 0);
    n = 0;
    while (!Done && !Error && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL job_end_timeout: no Done/Error within %0d cycles", n);
    end
    if (err) chk("err_latency", cyc - last_go_cyc, tmo + 2);
    @(negedge Clk);
    chk("queues_drained", exp_q.size() + dly_q.size(), 0);
  endtask

  initial begin
    int g, n;
    repeat (3) @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_go", {eng.GoRead, eng.GoWrite}, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_addr", {eng.source_address, eng.destination_address}, 0);
    @(posedge Clk); #1 Rst_n = 1'b1;

    run_job(0, 30'h100, 30'h0, 30'd2, 3, 20, 4, -1);
    run_job(2, 30'h300, 30'h200, 30'd1, 2, 20, 0, -1);
    run_job(0, 30'h40, 30'h0, 30'd1, 3, 5, 0, 0);
    chk("error_sticky", Error, 1);
    @(posedge Clk); #1 Abort = 1'b1;
    @(posedge Clk); #1 Abort = 1'b0;
    @(negedge Clk);
    chk("abort_clears_error", Error, 0);
    run_job(1, 30'h0, 30'h80, 30'd1, 0, 4, 0, -1);
    run_job(0, 30'h3FFFFFFF, 30'h0, 30'd1, 2, 6, 0, -1);

    // Abort in the second WAIT_WR, with a Start in the same cycle.
    exp_q.push_back('{1, 30'h500, 0});
    exp_q.push_back('{1, 30'h504, 0});
    dly_q.push_back(3);
    dly_q.push_back(0);
    cfg_mode = MODE_WR; cfg_dst_base = 30'h500; cfg_stride = 30'd4;
    cfg_count = 16'd3; cfg_timeout = 16'd20;
    pulse_start();
    g = 0; n = 0;
    while (g < 2 && n < 200) begin
      @(negedge Clk);
      n++;
      if (eng.GoWrite) g++;
    end
    chk("abort_saw_two_writes", g, 2);
    @(posedge Clk); #1;
    Abort = 1'b1; Start = 1'b1; cfg_mode = MODE_RD; cfg_count = 16'd5;
    @(posedge Clk); #1 Abort = 1'b0; Start = 1'b0;
    @(negedge Clk);
    chk("abort_idle", Busy, 0);
    chk("abort_error", Error, 0);
    chk("abort_iter_hold", iter_cnt, 1);
    repeat (10) @(negedge Clk);
    chk("abort_start_ignored", Busy, 0);
    chk("abort_queues", exp_q.size() + dly_q.size(), 0);

    for (int j = 0; j < 25; j++)
      run_job(int'($urandom_range(0, 3)), AW'($urandom()), AW'($urandom()), AW'($urandom()),
              int'($urandom_range(0, 5)), int'($urandom_range(1, 8)), 0,
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
